// File: rtl/pcs_sync_param_if.sv
// rtl/pcs_sync_param_if.sv - PMA-side inputs and receive-FSM-side outputs of the PCS sync block
interface pcs_sync_param_if #(
  parameter int CG_WIDTH  = 10,
  parameter int CNT_WIDTH = 8
);
  logic                  indicate;
  logic [CG_WIDTH-1:0]   pudi;
  logic                  cg_invalid;
  logic                  signal_detect;
  logic                  code_sync_status;
  logic                  rx_even;
  logic [CG_WIDTH:0]     sudi;
  logic                  sudi_valid;
  logic                  sync_lost;
  logic [CNT_WIDTH-1:0]  loss_count;
  logic [1:0]            sync_state;

  // Aligner/decoder side that feeds code-groups in
  modport master (
    output indicate, pudi, cg_invalid, signal_detect,
    input  code_sync_status, rx_even, sudi, sudi_valid, sync_lost, loss_count, sync_state
  );

  // Synchronization FSM side
  modport slave (
    input  indicate, pudi, cg_invalid, signal_detect,
    output code_sync_status, rx_even, sudi, sudi_valid, sync_lost, loss_count, sync_state
  );
endinterface

// File: rtl/pcs_sync_param.sv
// rtl/pcs_sync_param.sv - parametrised 1000BASE-X PCS receive synchronization FSM
module pcs_sync_param #(
  parameter int CG_WIDTH     = 10,
  parameter int ACQ_COMMAS   = 3,
  parameter int LOSS_BADS    = 4,
  parameter int GOOD_RECOVER = 4,
  parameter int CNT_WIDTH    = 8
) (
  input  logic clk,
  input  logic mr_main_reset,
  pcs_sync_param_if.slave sif
);

  localparam int CC_W = $clog2(ACQ_COMMAS) + 1;
  localparam int BC_W = $clog2(LOSS_BADS) + 1;
  localparam int GC_W = $clog2(GOOD_RECOVER) + 1;

  typedef enum logic [1:0] {
    LOSS_OF_SYNC  = 2'd0,
    COMMA_DETECT  = 2'd1,
    ACQUIRE_SYNC  = 2'd2,
    SYNC_ACQUIRED = 2'd3
  } state_t;

  state_t               state_q;
  logic [CC_W-1:0]      comma_cnt;
  logic [BC_W-1:0]      bad_cnt;
  logic [GC_W-1:0]      good_cnt;
  logic                 rx_even_q;
  logic [CG_WIDTH:0]    sudi_q;
  logic                 sudi_valid_q;
  logic                 sync_lost_q;
  logic                 status_q;
  logic [CNT_WIDTH-1:0] loss_cnt_q;
  logic                 comma;
  logic                 cgbad;

  // Classify the presented code-group: comma pattern in the top seven bits, bad if invalid or misplaced comma
  always_comb begin
    comma = (sif.pudi[CG_WIDTH-1 -: 7] == 7'b0011111) ||
            (sif.pudi[CG_WIDTH-1 -: 7] == 7'b1100000);
    cgbad = sif.cg_invalid | (comma & rx_even_q);
  end

  // Synchronization state machine with registered outputs; signal_detect loss beats every other transition
  always_ff @(posedge clk or negedge mr_main_reset) begin
    if (!mr_main_reset) begin
      state_q      <= LOSS_OF_SYNC;
      comma_cnt    <= '0;
      bad_cnt      <= '0;
      good_cnt     <= '0;
      rx_even_q    <= 1'b0;
      sudi_q       <= '0;
      sudi_valid_q <= 1'b0;
      sync_lost_q  <= 1'b0;
      status_q     <= 1'b0;
      loss_cnt_q   <= '0;
    end else begin
      sudi_valid_q <= 1'b0;
      sync_lost_q  <= 1'b0;
      if (sif.indicate) begin
        sudi_valid_q <= 1'b1;
        rx_even_q    <= ~rx_even_q;
        sudi_q       <= {~rx_even_q, sif.pudi};
      end
      if (!sif.signal_detect) begin
        state_q   <= LOSS_OF_SYNC;
        status_q  <= 1'b0;
        comma_cnt <= '0;
        bad_cnt   <= '0;
        good_cnt  <= '0;
        if (state_q == SYNC_ACQUIRED) begin
          sync_lost_q <= 1'b1;
          if (loss_cnt_q != '1) loss_cnt_q <= loss_cnt_q + CNT_WIDTH'(1);
        end
      end else if (sif.indicate) begin
        case (state_q)
          LOSS_OF_SYNC: begin
            if (comma && !sif.cg_invalid) begin
              rx_even_q <= 1'b1;
              sudi_q    <= {1'b1, sif.pudi};
              comma_cnt <= CC_W'(1);
              state_q   <= COMMA_DETECT;
            end
          end
          COMMA_DETECT: begin
            if (!comma && !sif.cg_invalid) begin
              if (comma_cnt == CC_W'(ACQ_COMMAS)) begin
                state_q  <= SYNC_ACQUIRED;
                status_q <= 1'b1;
                bad_cnt  <= '0;
                good_cnt <= '0;
              end else begin
                state_q <= ACQUIRE_SYNC;
              end
            end else begin
              state_q   <= LOSS_OF_SYNC;
              comma_cnt <= '0;
            end
          end
          ACQUIRE_SYNC: begin
            if (comma && !rx_even_q && !sif.cg_invalid) begin
              rx_even_q <= 1'b1;
              sudi_q    <= {1'b1, sif.pudi};
              comma_cnt <= comma_cnt + CC_W'(1);
              state_q   <= COMMA_DETECT;
            end else if (cgbad) begin
              state_q   <= LOSS_OF_SYNC;
              comma_cnt <= '0;
            end
          end
          SYNC_ACQUIRED: begin
            if (cgbad) begin
              good_cnt <= '0;
              if ((bad_cnt + BC_W'(1)) == BC_W'(LOSS_BADS)) begin
                state_q     <= LOSS_OF_SYNC;
                status_q    <= 1'b0;
                sync_lost_q <= 1'b1;
                comma_cnt   <= '0;
                bad_cnt     <= '0;
                if (loss_cnt_q != '1) loss_cnt_q <= loss_cnt_q + CNT_WIDTH'(1);
              end else begin
                bad_cnt <= bad_cnt + BC_W'(1);
              end
            end else if (bad_cnt != '0) begin
              if ((good_cnt + GC_W'(1)) == GC_W'(GOOD_RECOVER)) begin
                bad_cnt  <= bad_cnt - BC_W'(1);
                good_cnt <= '0;
              end else begin
                good_cnt <= good_cnt + GC_W'(1);
              end
            end
          end
          default: state_q <= LOSS_OF_SYNC;
        endcase
      end
    end
  end

  assign sif.code_sync_status = status_q;
  assign sif.rx_even          = rx_even_q;
  assign sif.sudi             = sudi_q;
  assign sif.sudi_valid       = sudi_valid_q;
  assign sif.sync_lost        = sync_lost_q;
  assign sif.loss_count       = loss_cnt_q;
  assign sif.sync_state       = state_q;

endmodule

// File: tb/tb_pcs_sync_param.sv
// tb/tb_pcs_sync_param.sv - scoreboard bench for the PCS synchronization FSM
module tb_pcs_sync_param;
  localparam int CGW  = 10;
  localparam int CNTW = 2;
  localparam int ACQ  = 3;
  localparam int LOSS = 4;
  localparam int GR   = 4;
  localparam logic [9:0] K285 = 10'b0011111010;
  localparam logic [9:0] D162 = 10'b1001000101;

  typedef struct {
    bit          valid;
    logic [10:0] sudi;
    bit          cs;
    bit          lost;
    logic [1:0]  lc;
    logic [1:0]  st;
    bit          rx;
  } exp_t;

  logic clk = 1'b0;
  logic mr_main_reset;
  always #5 clk = ~clk;

  pcs_sync_param_if #(.CG_WIDTH(CGW), .CNT_WIDTH(CNTW)) bus ();

  pcs_sync_param #(
    .CG_WIDTH(CGW), .ACQ_COMMAS(ACQ), .LOSS_BADS(LOSS),
    .GOOD_RECOVER(GR), .CNT_WIDTH(CNTW)
  ) dut (
    .clk(clk),
    .mr_main_reset(mr_main_reset),
    .sif(bus.slave)
  );

  exp_t exp_q[$];
  exp_t mon_e;
  int n_checks = 0;
  int n_errors = 0;

  // Reference model: link phase 0 lost, 1 saw comma, 2 saw data after comma, 3 in sync
  int          m_phase;
  bit          m_rx;
  int          m_pairs, m_bad, m_good, m_losses;
  bit          m_valid, m_lost;
  logic [10:0] m_sudi;

  task automatic check(string name, logic [31:0] act, logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  task automatic model_reset();
    m_phase = 0; m_rx = 0; m_pairs = 0; m_bad = 0; m_good = 0;
    m_losses = 0; m_valid = 0; m_lost = 0; m_sudi = '0;
  endtask

  task automatic lose();
    m_lost = 1;
    if (m_losses < (1 << CNTW) - 1) m_losses++;
  endtask

  task automatic model_step(bit ind, logic [9:0] cg, bit inv, bit sd);
    bit is_comma, bad, force_even;
    is_comma   = (cg[9:3] == 7'b0011111) || (cg[9:3] == 7'b1100000);
    bad        = inv || (is_comma && m_rx);
    force_even = 0;
    m_valid    = ind;
    m_lost     = 0;
    if (!sd) begin
      if (m_phase == 3) lose();
      m_phase = 0; m_pairs = 0; m_bad = 0; m_good = 0;
    end else if (ind) begin
      case (m_phase)
        0: if (is_comma && !inv) begin force_even = 1; m_pairs = 1; m_phase = 1; end
        1: begin
          if (!is_comma && !inv) begin
            if (m_pairs == ACQ) begin m_phase = 3; m_bad = 0; m_good = 0; end
            else m_phase = 2;
          end else m_phase = 0;
        end
        2: begin
          if (is_comma && !m_rx && !inv) begin force_even = 1; m_pairs++; m_phase = 1; end
          else if (bad) m_phase = 0;
        end
        default: begin
          if (bad) begin
            m_good = 0;
            m_bad++;
            if (m_bad == LOSS) begin lose(); m_phase = 0; m_bad = 0; m_pairs = 0; end
          end else if (m_bad > 0) begin
            m_good++;
            if (m_good == GR) begin m_bad--; m_good = 0; end
          end
        end
      endcase
    end
    if (ind) begin
      m_rx   = force_even ? 1'b1 : !m_rx;
      m_sudi = {m_rx, cg};
    end
  endtask

  // Drive one cycle of stimulus (called at posedge+2) and queue the expected post-edge outputs
  task automatic cycle(bit rst, bit ind, logic [9:0] cg, bit inv, bit sd);
    exp_t e;
    mr_main_reset     = !rst;
    bus.indicate      = ind;
    bus.pudi          = cg;
    bus.cg_invalid    = inv;
    bus.signal_detect = sd;
    if (rst) model_reset();
    else model_step(ind, cg, inv, sd);
    e.valid = m_valid;
    e.sudi  = m_sudi;
    e.cs    = (m_phase == 3);
    e.lost  = m_lost;
    e.lc    = 2'(m_losses);
    e.st    = 2'(m_phase);
    e.rx    = m_rx;
    exp_q.push_back(e);
    @(posedge clk);
    #2;
  endtask

  task automatic acquire();
    repeat (ACQ) begin
      cycle(0, 1, K285, 0, 1);
      cycle(0, 1, D162, 0, 1);
    end
  endtask

  // Monitor: one sample per edge, compared against the oldest queued expectation
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        mon_e = exp_q.pop_front();
        check("sudi_valid", bus.sudi_valid, mon_e.valid);
        check("sudi", bus.sudi, mon_e.sudi);
        check("code_sync_status", bus.code_sync_status, mon_e.cs);
        check("sync_lost", bus.sync_lost, mon_e.lost);
        check("loss_count", bus.loss_count, mon_e.lc);
        check("sync_state", bus.sync_state, mon_e.st);
        check("rx_even", bus.rx_even, mon_e.rx);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int ind_cnt;
    logic [9:0] cg;
    mr_main_reset     = 1'b0;
    bus.indicate      = 1'b0;
    bus.pudi          = '0;
    bus.cg_invalid    = 1'b0;
    bus.signal_detect = 1'b0;
    model_reset();
    @(posedge clk);
    #2;

    repeat (3) cycle(1, 1'($urandom_range(0, 1)), 10'($urandom), 0, 1);
    repeat (2) cycle(0, 0, 10'($urandom), 0, 1);

    acquire();
    repeat (4) cycle(0, 1, D162, 1, 1);

    acquire();
    repeat (3) cycle(0, 1, D162, 1, 1);
    repeat (4) cycle(0, 1, D162, 0, 1);
    cycle(0, 1, D162, 1, 1);
    cycle(0, 1, D162, 1, 1);

    acquire();
    cycle(0, 1, D162, 0, 1);
    cycle(0, 1, K285, 0, 1);
    cycle(0, 0, D162, 0, 0);

    cycle(0, 1, K285, 0, 1);
    cycle(0, 1, D162, 0, 1);
    cycle(0, 1, D162, 0, 1);
    cycle(0, 1, K285, 0, 1);

    cycle(0, 1, K285, 0, 1);
    cycle(0, 1, K285, 0, 1);

    repeat (2) begin
      acquire();
      cycle(0, 0, D162, 0, 0);
    end

    ind_cnt = 0;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 99) < 85) cg = (ind_cnt % 2 == 0) ? K285 : D162;
      else if ($urandom_range(0, 1) == 1) cg = K285;
      else cg = 10'($urandom);
      if ($urandom_range(0, 3) != 0) begin
        ind_cnt++;
        cycle(0, 1, cg, ($urandom_range(0, 24) == 0), ($urandom_range(0, 59) != 0));
      end else begin
        cycle(0, 0, cg, 0, ($urandom_range(0, 59) != 0));
      end
    end

    cycle(0, 0, D162, 0, 0);
    acquire();
    cycle(0, 1, K285, 0, 1);
    cycle(0, 1, D162, 0, 1);
    mr_main_reset = 1'b0;
    #1;
    check("reset_now_state", bus.sync_state, 2'd0);
    check("reset_now_status", bus.code_sync_status, 1'b0);
    check("reset_now_loss_count", bus.loss_count, 2'd0);
    check("reset_now_sync_lost", bus.sync_lost, 1'b0);
    check("reset_now_rx_even", bus.rx_even, 1'b0);
    repeat (2) cycle(1, 1, K285, 0, 1);
    cycle(0, 0, D162, 0, 1);

    check("queue_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
